// File: rtl/program_memory_loader_pkg.sv
// program_memory_loader_pkg
//   Shared definitions for the program memory loader slice.
//   - Loader FSM state encoding.
//   - Default fetch address / instruction widths.
//   - Memory depth constant and a helper to derive depth from an address width.
package program_memory_loader_pkg;

  localparam int PML_ADDR_W = 6;
  localparam int PML_DATA_W = 8;
  localparam int PML_DEPTH  = 2 ** PML_ADDR_W;

  // CHECK and ERROR are only reachable when PROGRAM_LOADER_CHECKSUM_EN is defined.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_CHECK = 3'd2,
    ST_RUN   = 3'd3,
    ST_ERROR = 3'd4
  } loader_state_e;

  function automatic int depth_of(input int addr_w);
    return 2 ** addr_w;
  endfunction

endpackage

// File: rtl/program_memory_loader_if.sv
// program_memory_loader_if
//   Bundles the loader's byte-stream port and the CPU fetch/run port.
//   Load side : LOAD_START, LOAD_VALID, LOAD_LAST, LOAD_DATA -> block; LOAD_READY <- block.
//   CPU side  : MEMORY_ADDR -> block; MEMORY_DATA, CPU_RUN <- block.
//   Status    : LOAD_ERROR, LOADED_WORDS <- block.
//   Modports: master = producer/CPU side (testbench), slave = the loader.
interface program_memory_loader_if
  import program_memory_loader_pkg::*;
#(
  parameter int ADDR_W = PML_ADDR_W,
  parameter int DATA_W = PML_DATA_W
);

  logic              LOAD_START;
  logic              LOAD_VALID;
  logic              LOAD_LAST;
  logic [DATA_W-1:0] LOAD_DATA;
  logic              LOAD_READY;
  logic [ADDR_W-1:0] MEMORY_ADDR;
  logic [DATA_W-1:0] MEMORY_DATA;
  logic              CPU_RUN;
  logic              LOAD_ERROR;
  logic [ADDR_W:0]   LOADED_WORDS;

  modport master (
    output LOAD_START, LOAD_VALID, LOAD_LAST, LOAD_DATA, MEMORY_ADDR,
    input  LOAD_READY, MEMORY_DATA, CPU_RUN, LOAD_ERROR, LOADED_WORDS
  );

  modport slave (
    input  LOAD_START, LOAD_VALID, LOAD_LAST, LOAD_DATA, MEMORY_ADDR,
    output LOAD_READY, MEMORY_DATA, CPU_RUN, LOAD_ERROR, LOADED_WORDS
  );

endinterface

// File: rtl/program_memory_loader_ram.sv
// program_ram
//   2**ADDR_W x DATA_W flop array holding the CPU program.
//   Ports:
//     CLOCK, RESET : clock; synchronous active-high reset clears every word to 0.
//     wr_en, wr_addr, wr_data : synchronous write port.
//     rd_addr, rd_data        : asynchronous read port (CPU fetch).
//   Built from flops rather than block RAM because every word must clear on
//   reset and the fetch path is combinational.
module program_ram
  import program_memory_loader_pkg::*;
#(
  parameter int ADDR_W = PML_ADDR_W,
  parameter int DATA_W = PML_DATA_W
) (
  input  logic              CLOCK,
  input  logic              RESET,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  localparam int DEPTH = depth_of(ADDR_W);

  logic [DATA_W-1:0] mem_reg [DEPTH];

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_word
      always_ff @(posedge CLOCK) begin
        if (RESET) begin
          mem_reg[gi] <= '0;
        end else if (wr_en && (wr_addr == ADDR_W'(gi))) begin
          mem_reg[gi] <= wr_data;
        end
      end
    end
  endgenerate

  // Depth is exactly 2**ADDR_W, so every address value indexes a real word.
  assign rd_data = mem_reg[rd_addr];

endmodule

// File: rtl/program_memory_loader.sv
// program_memory_loader
//   Instruction memory in front of the CPU. Programs are streamed in byte by
//   byte over a valid/ready port while the CPU is held; on completion CPU_RUN
//   releases the CPU. Fetch (MEMORY_ADDR -> MEMORY_DATA) is combinational.
//   Ports:
//     CLOCK, RESET : clock; synchronous active-high reset.
//     bus (slave)  : load stream, fetch port, CPU_RUN, LOAD_ERROR, LOADED_WORDS.
//   Parameters ADDR_W/DATA_W must match the connected interface instance.
//   Optional feature macro: PROGRAM_LOADER_CHECKSUM_EN
//     Defined     : one checksum byte follows the program; (sum of program
//                   bytes + checksum) mod 256 must be 0, else ERROR state with
//                   LOAD_ERROR high and the CPU kept held.
//     Not defined : the last program byte releases the CPU directly and
//                   LOAD_ERROR is constant 0.
module program_memory_loader
  import program_memory_loader_pkg::*;
#(
  parameter int ADDR_W = PML_ADDR_W,
  parameter int DATA_W = PML_DATA_W
) (
  input  logic                    CLOCK,
  input  logic                    RESET,
  program_memory_loader_if.slave  bus
);

  loader_state_e     state_reg, state_next;
  logic [ADDR_W:0]   loaded_words_reg;
  logic              cpu_run_reg;
  logic              load_ready;
  logic              accept;
  logic              clear_load;
  logic              wr_en;
  logic [ADDR_W-1:0] ptr;

  // The write pointer is the low bits of the word count; the count itself
  // needs one extra bit to represent a full 2**ADDR_W load.
  assign ptr = loaded_words_reg[ADDR_W-1:0];

  // A start pulse takes priority over any byte presented in the same cycle.
  assign load_ready = ((state_reg == ST_LOAD) || (state_reg == ST_CHECK)) && !bus.LOAD_START;
  assign accept     = bus.LOAD_VALID && load_ready;

`ifdef PROGRAM_LOADER_CHECKSUM_EN
  logic [DATA_W-1:0] sum_reg;
  logic [DATA_W-1:0] sum_plus_data;
  logic              load_error_reg;

  assign sum_plus_data = sum_reg + bus.LOAD_DATA;
`endif

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    clear_load = 1'b0;
    wr_en      = 1'b0;
    case (state_reg)
      ST_LOAD: begin
        if (bus.LOAD_START) begin
          clear_load = 1'b1;
          state_next = ST_LOAD;
        end else if (accept) begin
          wr_en = 1'b1;
          // The final word forces the end of the load regardless of LOAD_LAST.
          if (bus.LOAD_LAST || (&ptr)) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            state_next = ST_CHECK;
`else
            state_next = ST_RUN;
`endif
          end
        end
      end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      ST_CHECK: begin
        if (bus.LOAD_START) begin
          clear_load = 1'b1;
          state_next = ST_LOAD;
        end else if (accept) begin
          state_next = (sum_plus_data == '0) ? ST_RUN : ST_ERROR;
        end
      end
`endif
      default: begin
        // IDLE, RUN, ERROR: only a start pulse moves the FSM.
        if (bus.LOAD_START) begin
          clear_load = 1'b1;
          state_next = ST_LOAD;
        end
      end
    endcase
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      loaded_words_reg <= '0;
      cpu_run_reg      <= 1'b0;
    end else begin
      // Registered from the next state so the CPU is held at the very edge
      // a restart is taken, before any memory word is overwritten.
      cpu_run_reg <= (state_next == ST_RUN);
      if (clear_load) begin
        loaded_words_reg <= '0;
      end else if (wr_en) begin
        loaded_words_reg <= loaded_words_reg + {{ADDR_W{1'b0}}, 1'b1};
      end
    end
  end

`ifdef PROGRAM_LOADER_CHECKSUM_EN
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      sum_reg        <= '0;
      load_error_reg <= 1'b0;
    end else begin
      load_error_reg <= (state_next == ST_ERROR);
      if (clear_load) begin
        sum_reg <= '0;
      end else if (wr_en) begin
        sum_reg <= sum_plus_data;
      end
    end
  end

  assign bus.LOAD_ERROR = load_error_reg;
`else
  assign bus.LOAD_ERROR = 1'b0;
`endif

  program_ram #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_ram (
    .CLOCK   (CLOCK),
    .RESET   (RESET),
    .wr_en   (wr_en),
    .wr_addr (ptr),
    .wr_data (bus.LOAD_DATA),
    .rd_addr (bus.MEMORY_ADDR),
    .rd_data (bus.MEMORY_DATA)
  );

  assign bus.LOAD_READY   = load_ready;
  assign bus.CPU_RUN      = cpu_run_reg;
  assign bus.LOADED_WORDS = loaded_words_reg;

endmodule

// File: tb/tb_program_memory_loader.sv
// tb_program_memory_loader
//   Table-driven bench for program_memory_loader: each vector drives one cycle
//   of the load port and states the expected LOAD_READY (before the edge) and
//   CPU_RUN / LOAD_ERROR / LOADED_WORDS (after the edge). Bytes expected to be
//   written are pushed to a scoreboard queue and later read back through the
//   fetch port. Checksum vectors are compiled when PROGRAM_LOADER_CHECKSUM_EN
//   is defined.
module tb_program_memory_loader;

  logic CLOCK = 1'b0;
  logic RESET = 1'b1;

  program_memory_loader_if #(.ADDR_W(6), .DATA_W(8)) bus ();

  program_memory_loader #(.ADDR_W(6), .DATA_W(8)) dut (
    .CLOCK (CLOCK),
    .RESET (RESET),
    .bus   (bus.slave)
  );

  always #5 CLOCK = ~CLOCK;

  typedef struct {
    bit       start;
    bit       valid;
    bit       last;
    bit [7:0] data;
    bit       wr;
    bit       exp_ready;
    bit       exp_run;
    bit       exp_err;
    int       exp_words;
  } vec_t;

  typedef struct {
    bit [5:0] addr;
    bit [7:0] data;
  } sb_t;

  vec_t vecs[$];
  sb_t  sb_q[$];
  int   wr_ptr   = 0;
  int   checks   = 0;
  int   failures = 0;

  function automatic vec_t mk(bit start, bit valid, bit last, bit [7:0] data, bit wr,
                              bit exp_ready, bit exp_run, bit exp_err, int exp_words);
    vec_t v;
    v.start = start; v.valid = valid; v.last = last; v.data = data; v.wr = wr;
    v.exp_ready = exp_ready; v.exp_run = exp_run; v.exp_err = exp_err; v.exp_words = exp_words;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.LOAD_START = 1'b0;
    bus.LOAD_VALID = 1'b0;
    bus.LOAD_LAST  = 1'b0;
    bus.LOAD_DATA  = 8'h00;
  endtask

  task automatic realign();
    @(posedge CLOCK);
    #1;
  endtask

  task automatic read_chk(input bit [5:0] addr, input bit [7:0] exp, input string name);
    bus.MEMORY_ADDR = addr;
    #1;
    chk($sformatf("%s[%0h]", name, addr), {24'h0, bus.MEMORY_DATA}, {24'h0, exp});
  endtask

  // Pop every pending write and compare it against the fetch port.
  task automatic drain();
    sb_t e;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      read_chk(e.addr, e.data, "mem");
    end
    realign();
  endtask

  task automatic apply_vec(input vec_t v, input int idx);
    if (v.start) begin
      if (sb_q.size() > 0) drain();
      wr_ptr = 0;
    end
    bus.LOAD_START = v.start;
    bus.LOAD_VALID = v.valid;
    bus.LOAD_LAST  = v.last;
    bus.LOAD_DATA  = v.data;
    @(negedge CLOCK);
    chk($sformatf("ready v%0d", idx), {31'h0, bus.LOAD_READY}, {31'h0, v.exp_ready});
    if (v.wr) begin
      sb_q.push_back('{addr: 6'(wr_ptr), data: v.data});
      wr_ptr++;
    end
    @(posedge CLOCK);
    #1;
    idle_inputs();
    chk($sformatf("run v%0d", idx),   {31'h0, bus.CPU_RUN},    {31'h0, v.exp_run});
    chk($sformatf("err v%0d", idx),   {31'h0, bus.LOAD_ERROR}, {31'h0, v.exp_err});
    chk($sformatf("words v%0d", idx), {25'h0, bus.LOADED_WORDS}, 32'(v.exp_words));
    $display("vec %0d start=%0b valid=%0b last=%0b data=%02h -> run=%0b err=%0b words=%0d",
             idx, v.start, v.valid, v.last, v.data, bus.CPU_RUN, bus.LOAD_ERROR, bus.LOADED_WORDS);
  endtask

  task automatic run_table();
    for (int i = 0; i < vecs.size(); i++) apply_vec(vecs[i], i);
    vecs.delete();
  endtask

  initial begin
    idle_inputs();
    bus.MEMORY_ADDR = '0;
    RESET = 1'b1;
    repeat (2) @(posedge CLOCK);
    #1;
    chk("rst run",   {31'h0, bus.CPU_RUN},    32'h0);
    chk("rst ready", {31'h0, bus.LOAD_READY}, 32'h0);
    chk("rst err",   {31'h0, bus.LOAD_ERROR}, 32'h0);
    chk("rst words", {25'h0, bus.LOADED_WORDS}, 32'h0);
    RESET = 1'b0;

    // Short load C1,40,FF with a producer stall; a byte in RUN is ignored.
    vecs.push_back(mk(1, 0, 0, 8'h00, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 8'hC1, 1, 1, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 8'h00, 0, 1, 0, 0, 1));
    vecs.push_back(mk(0, 1, 0, 8'h40, 1, 1, 0, 0, 2));
    vecs.push_back(mk(0, 1, 1, 8'hFF, 1, 1, 1, 0, 3));
    vecs.push_back(mk(0, 1, 0, 8'h55, 0, 0, 1, 0, 3));
    run_table();
    drain();
    read_chk(6'd3, 8'h00, "short_tail");
    realign();

    // Full 64-byte load, LOAD_LAST never set: forced end after byte 3F.
    vecs.push_back(mk(1, 0, 0, 8'h00, 0, 0, 0, 0, 0));
    for (int i = 0; i < 64; i++)
      vecs.push_back(mk(0, 1, 0, 8'(i), 1, 1, (i == 63), 0, i + 1));
    vecs.push_back(mk(0, 1, 1, 8'hAA, 0, 0, 1, 0, 64));
    run_table();
    drain();

    // Restart from RUN: CPU held before memory changes; 1-byte reload.
    vecs.push_back(mk(1, 0, 0, 8'h00, 0, 0, 0, 0, 0));
    run_table();
    read_chk(6'd0, 8'h00, "held_old");
    realign();
    vecs.push_back(mk(0, 1, 1, 8'h80, 1, 1, 1, 0, 1));
    run_table();
    drain();
    read_chk(6'd1, 8'h01, "keep_old");
    realign();

    // Restart mid-load with a byte presented alongside the start pulse.
    vecs.push_back(mk(1, 0, 0, 8'h00, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 8'hA0, 1, 1, 0, 0, 1));
    vecs.push_back(mk(0, 1, 0, 8'hA1, 1, 1, 0, 0, 2));
    vecs.push_back(mk(1, 1, 0, 8'hA2, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 8'hB0, 1, 1, 0, 0, 1));
    vecs.push_back(mk(0, 1, 1, 8'hB1, 1, 1, 1, 0, 2));
    run_table();
    drain();
    read_chk(6'd2, 8'h02, "rejected_byte");
    realign();

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    // Good checksum 10+20+D0 = 0 mod 256, then bad checksum D1 -> ERROR.
    vecs.push_back(mk(1, 0, 0, 8'h00, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 8'h10, 1, 1, 0, 0, 1));
    vecs.push_back(mk(0, 1, 1, 8'h20, 1, 1, 0, 0, 2));
    vecs.push_back(mk(0, 1, 1, 8'hD0, 0, 1, 1, 0, 2));
    vecs.push_back(mk(1, 0, 0, 8'h00, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 8'h10, 1, 1, 0, 0, 1));
    vecs.push_back(mk(0, 1, 1, 8'h20, 1, 1, 0, 0, 2));
    vecs.push_back(mk(0, 1, 1, 8'hD1, 0, 1, 0, 1, 2));
    vecs.push_back(mk(0, 1, 1, 8'h00, 0, 0, 0, 1, 2));
    vecs.push_back(mk(1, 0, 0, 8'h00, 0, 0, 0, 0, 0));
    run_table();
    sb_q.delete();
`endif

    // Reset in the middle of a load.
    vecs.push_back(mk(1, 0, 0, 8'h00, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 8'h77, 1, 1, 0, 0, 1));
    run_table();
    sb_q.delete();
    bus.LOAD_VALID = 1'b1;
    bus.LOAD_DATA  = 8'h99;
    RESET = 1'b1;
    realign();
    chk("rstload run",   {31'h0, bus.CPU_RUN},    32'h0);
    chk("rstload ready", {31'h0, bus.LOAD_READY}, 32'h0);
    chk("rstload err",   {31'h0, bus.LOAD_ERROR}, 32'h0);
    chk("rstload words", {25'h0, bus.LOADED_WORDS}, 32'h0);
    RESET = 1'b0;
    idle_inputs();
    for (int a = 0; a < 64; a++) read_chk(6'(a), 8'h00, "cleared");
    realign();

    // Reset while the CPU is running.
    vecs.push_back(mk(1, 0, 0, 8'h00, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 1, 8'h5A, 1, 1, 1, 0, 1));
    run_table();
    sb_q.delete();
    RESET = 1'b1;
    realign();
    chk("rstrun run",   {31'h0, bus.CPU_RUN},    32'h0);
    chk("rstrun words", {25'h0, bus.LOADED_WORDS}, 32'h0);
    RESET = 1'b0;
    read_chk(6'd0, 8'h00, "rstrun_mem");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
